// File: rtl/perceptron_update_pkg.sv
// Shared constants, FSM encoding and write-record layout for the perceptron training stage.
package perceptron_update_pkg;

  localparam int W_WIDTH    = 8;
  localparam int GHR_SIZE   = 12;
  localparam int HOB        = 3;
  localparam int LOB        = W_WIDTH - HOB;
  localparam int ENTRIES    = 64;
  localparam int ADDR_W     = $clog2(ENTRIES);
  localparam int THETA      = 1;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [HOB*GHR_SIZE-1:0] hob;
    logic [HOB*GHR_SIZE-1:0] hob_c;
    logic [LOB*GHR_SIZE-1:0] lob;
  } wr_t;

endpackage

// File: rtl/perceptron_weight_sat.sv
// One weight lane: saturating +/-1, saturated negation, and the HOB / HOB-of-negation / LOB slices.
// Purely combinational.
module perceptron_weight_sat
  import perceptron_update_pkg::*;
(
  input  logic [W_WIDTH-1:0] w,
  input  logic               inc,
  output logic [HOB-1:0]     hob,
  output logic [HOB-1:0]     hob_c,
  output logic [LOB-1:0]     lob
);

  logic [W_WIDTH-1:0] w_new;
  logic [W_WIDTH-1:0] w_neg;
  logic               unused_neg_lob;

  always_comb begin
    w_new = w;
    if (inc) begin
      if (w != 8'h7F) w_new = w + 8'd1;
    end else begin
      if (w != 8'h80) w_new = w - 8'd1;
    end
    // -(-128) does not fit, so it clamps to +127
    w_neg = (w_new == 8'h80) ? 8'h7F : (8'd0 - w_new);
  end

  assign hob            = w_new[W_WIDTH-1:LOB];
  assign hob_c          = w_neg[W_WIDTH-1:LOB];
  assign lob            = w_new[LOB-1:0];
  assign unused_neg_lob = ^w_neg[LOB-1:0];

endmodule

// File: rtl/perceptron_update.sv
// Perceptron training stage: decides whether to train, builds saturated weight write data, and
// queues table writes across predictor stalls; clears the tables after reset.
module perceptron_update
  import perceptron_update_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        up_valid,
  output logic                        up_ready,
  input  logic [31:0]                 up_PC4,
  input  logic                        up_dir,
  input  logic                        up_miss,
  input  logic [GHR_SIZE-1:0]         up_ghr,
  input  logic [W_WIDTH*GHR_SIZE-1:0] up_weights,
  input  logic [6:0]                  up_sum,
  input  logic                        stall,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [HOB*GHR_SIZE-1:0]     wr_hob,
  output logic [HOB*GHR_SIZE-1:0]     wr_hob_c,
  output logic [LOB*GHR_SIZE-1:0]     wr_lob,
  output logic [31:0]                 train_count,
  output logic [31:0]                 skip_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] sweep_idx;

  logic                        a_vld, a_train, a_dir;
  logic [ADDR_W-1:0]           a_addr;
  logic [GHR_SIZE-1:0]         a_ghr;
  logic [W_WIDTH*GHR_SIZE-1:0] a_weights;

  wr_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [PTR_W+1:0] occ;

  logic [HOB*GHR_SIZE-1:0] b_hob, b_hob_c;
  logic [LOB*GHR_SIZE-1:0] b_lob;
  wr_t                     b_ent;

  wr_t  out_q, out_d;
  logic out_en_d;
  logic accept, push, pop, up_train;
  logic [7:0] sum8, sum_abs;
  logic unused_pc;

  assign sum8      = {up_sum[6], up_sum};
  assign sum_abs   = sum8[7] ? (8'd0 - sum8) : sum8;
  assign up_train  = up_miss | (sum_abs <= 8'(THETA));
  assign unused_pc = ^{up_PC4[31:8], up_PC4[1:0]};

  assign accept = up_valid & up_ready;
  assign push   = a_vld & a_train;
  assign pop    = (state_q == ST_RUN) & (fifo_cnt != '0) & ~stall;
  assign occ    = {1'b0, fifo_cnt} + {{(PTR_W + 1){1'b0}}, a_vld};

  for (genvar i = 0; i < GHR_SIZE; i++) begin : g_lane
    perceptron_weight_sat u_sat (
      .w     (a_weights[W_WIDTH*i +: W_WIDTH]),
      .inc   (a_ghr[i] == a_dir),
      .hob   (b_hob[HOB*i +: HOB]),
      .hob_c (b_hob_c[HOB*i +: HOB]),
      .lob   (b_lob[LOB*i +: LOB])
    );
  end

  assign b_ent = '{addr: a_addr, hob: b_hob, hob_c: b_hob_c, lob: b_lob};

  always_comb begin
    state_d  = state_q;
    up_ready = 1'b0;
    out_en_d = 1'b0;
    out_d    = out_q;
    case (state_q)
      ST_INIT: begin
        out_en_d   = 1'b1;
        out_d      = '0;
        out_d.addr = sweep_idx;
        if (sweep_idx == ADDR_W'(ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Stage A always drains next cycle, so it must be reserved a FIFO slot
        up_ready = occ < (PTR_W + 2)'(FIFO_DEPTH);
        if (pop) begin
          out_en_d = 1'b1;
          out_d    = fifo_mem[rd_ptr];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_idx   <= '0;
      wr_en       <= 1'b0;
      out_q       <= '0;
      a_vld       <= 1'b0;
      a_train     <= 1'b0;
      a_dir       <= 1'b0;
      a_addr      <= '0;
      a_ghr       <= '0;
      a_weights   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      train_count <= '0;
      skip_count  <= '0;
    end else begin
      state_q <= state_d;
      wr_en   <= out_en_d;
      out_q   <= out_d;
      if (state_q == ST_INIT) sweep_idx <= sweep_idx + 1'b1;

      a_vld <= accept;
      if (accept) begin
        a_train   <= up_train;
        a_dir     <= up_dir;
        a_addr    <= up_PC4[7:2] - 1'b1;
        a_ghr     <= up_ghr;
        a_weights <= up_weights;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;

      if (push)                 train_count <= train_count + 32'd1;
      if (a_vld && !a_train)    skip_count  <= skip_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= b_ent;
  end

  assign wr_addr  = out_q.addr;
  assign wr_hob   = out_q.hob;
  assign wr_hob_c = out_q.hob_c;
  assign wr_lob   = out_q.lob;

endmodule

// File: tb/tb_perceptron_update.sv
// Directed bench for perceptron_update: init sweep, weight update vectors, stall buffering, async reset.
module tb_perceptron_update;
  import perceptron_update_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        up_valid, up_ready, up_dir, up_miss, stall, wr_en;
  logic [31:0] up_PC4, train_count, skip_count;
  logic [11:0] up_ghr;
  logic [95:0] up_weights;
  logic [6:0]  up_sum;
  logic [5:0]  wr_addr;
  logic [35:0] wr_hob, wr_hob_c;
  logic [59:0] wr_lob;

  int errors = 0;
  int checks = 0;
  int exp_train = 0;
  int exp_skip = 0;

  perceptron_update dut (
    .clk(clk), .reset(reset), .up_valid(up_valid), .up_ready(up_ready), .up_PC4(up_PC4),
    .up_dir(up_dir), .up_miss(up_miss), .up_ghr(up_ghr), .up_weights(up_weights),
    .up_sum(up_sum), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_hob(wr_hob),
    .wr_hob_c(wr_hob_c), .wr_lob(wr_lob), .train_count(train_count), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc4;
    logic        dir;
    logic        miss;
    logic [11:0] ghr;
    logic [7:0]  w;
    logic [6:0]  sum;
    logic        e_wr;
    logic [5:0]  e_addr;
    logic [2:0]  e_hob;
    logic [2:0]  e_hobc;
    logic [4:0]  e_lob;
  } vec_t;

  vec_t vecs [10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_train"}, 64'(train_count), 64'(exp_train));
    chk({name, "_skip"}, 64'(skip_count), 64'(exp_skip));
  endtask

  task automatic init_sweep(input string name);
    for (int k = 0; k < ENTRIES; k++) begin
      tick;
      chk({name, "_wr_en"}, 64'(wr_en), 64'd1);
      chk({name, "_addr"}, 64'(wr_addr), 64'(k));
      chk({name, "_data"}, 64'(|{wr_hob, wr_hob_c, wr_lob}), 64'd0);
      if (k < ENTRIES - 1) chk({name, "_ready"}, 64'(up_ready), 64'd0);
    end
    tick;
    chk({name, "_done_wr_en"}, 64'(wr_en), 64'd0);
    chk({name, "_done_ready"}, 64'(up_ready), 64'd1);
  endtask

  // Update k of a stalled batch: addr k, all weights k, all lanes agree -> weight k+1
  task automatic drive_batch(input int k);
    up_PC4     = 32'h104 + 32'(4 * k);
    up_dir     = 1'b1;
    up_miss    = 1'b1;
    up_ghr     = 12'hFFF;
    up_weights = {12{8'(k)}};
    up_sum     = 7'd20;
  endtask

  task automatic offer_stalled(input int n_off, output int n_acc, output int wr_seen);
    logic acc;
    n_acc = 0;
    wr_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (n_acc < n_off) begin
        drive_batch(n_acc);
        up_valid = 1'b1;
      end else begin
        up_valid = 1'b0;
      end
      acc = up_valid & up_ready;
      tick;
      if (acc) n_acc++;
      if (wr_en) wr_seen++;
    end
    up_valid = 1'b0;
  endtask

  initial begin
    int n_acc, wr_seen, nwr, first_c, last_c;
    logic [35:0] e_hob, e_hobc;
    logic [59:0] e_lob;

    vecs[0] = '{32'h108, 1'b1, 1'b1, 12'hFFF, 8'h00, 7'd0,   1'b1, 6'd1,  3'b000, 3'b111, 5'b00001};
    vecs[1] = '{32'h204, 1'b1, 1'b1, 12'hFFF, 8'h7F, 7'd20,  1'b1, 6'd0,  3'b011, 3'b100, 5'b11111};
    vecs[2] = '{32'h010, 1'b0, 1'b1, 12'hFFF, 8'h80, 7'd20,  1'b1, 6'd3,  3'b100, 3'b011, 5'b00000};
    vecs[3] = '{32'h050, 1'b1, 1'b0, 12'hFFF, 8'h00, 7'd10,  1'b0, 6'd0,  3'b000, 3'b000, 5'b00000};
    vecs[4] = '{32'h0FC, 1'b1, 1'b0, 12'h000, 8'h05, 7'h7F,  1'b1, 6'd62, 3'b000, 3'b111, 5'b00100};
    vecs[5] = '{32'h050, 1'b1, 1'b0, 12'hFFF, 8'h00, 7'h40,  1'b0, 6'd0,  3'b000, 3'b000, 5'b00000};
    vecs[6] = '{32'h084, 1'b1, 1'b0, 12'hFFF, 8'hFF, 7'd1,   1'b1, 6'd32, 3'b000, 3'b000, 5'b00000};
    vecs[7] = '{32'h050, 1'b1, 1'b0, 12'hFFF, 8'h00, 7'd2,   1'b0, 6'd0,  3'b000, 3'b000, 5'b00000};
    vecs[8] = '{32'h044, 1'b1, 1'b1, 12'h000, 8'h81, 7'd3,   1'b1, 6'd16, 3'b100, 3'b011, 5'b00000};
    vecs[9] = '{32'h3FC, 1'b0, 1'b1, 12'h000, 8'h10, 7'd30,  1'b1, 6'd62, 3'b000, 3'b111, 5'b10001};

    reset = 1'b1; up_valid = 1'b0; up_PC4 = '0; up_dir = 1'b0; up_miss = 1'b0;
    up_ghr = '0; up_weights = '0; up_sum = '0; stall = 1'b0;
    repeat (3) tick;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_ready", 64'(up_ready), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(|{wr_hob, wr_hob_c, wr_lob}), 64'd0);
    chk_counters("rst");

    reset = 1'b0;
    init_sweep("init");

    foreach (vecs[v]) begin
      up_PC4 = vecs[v].pc4; up_dir = vecs[v].dir; up_miss = vecs[v].miss;
      up_ghr = vecs[v].ghr; up_weights = {12{vecs[v].w}}; up_sum = vecs[v].sum;
      up_valid = 1'b1;
      chk($sformatf("v%0d_ready", v), 64'(up_ready), 64'd1);
      tick;
      up_valid = 1'b0;
      tick;
      chk($sformatf("v%0d_lat1", v), 64'(wr_en), 64'd0);
      tick;
      if (vecs[v].e_wr) exp_train++; else exp_skip++;
      chk($sformatf("v%0d_wr_en", v), 64'(wr_en), 64'(vecs[v].e_wr));
      if (vecs[v].e_wr) begin
        chk($sformatf("v%0d_addr", v), 64'(wr_addr), 64'(vecs[v].e_addr));
        chk($sformatf("v%0d_hob", v), 64'(wr_hob), 64'({12{vecs[v].e_hob}}));
        chk($sformatf("v%0d_hob_c", v), 64'(wr_hob_c), 64'({12{vecs[v].e_hobc}}));
        chk($sformatf("v%0d_lob", v), 64'(wr_lob), 64'({12{vecs[v].e_lob}}));
      end
      chk_counters($sformatf("v%0d", v));
      tick;
    end

    // Mixed lanes: odd lanes agree (0 -> 1), even lanes disagree (0 -> -1)
    up_PC4 = 32'h00C; up_dir = 1'b1; up_miss = 1'b1; up_ghr = 12'hAAA;
    up_weights = '0; up_sum = 7'd5; up_valid = 1'b1;
    tick;
    up_valid = 1'b0;
    tick;
    tick;
    exp_train++;
    for (int i = 0; i < 12; i++) begin
      e_hob[3*i +: 3]  = (i % 2 == 1) ? 3'b000 : 3'b111;
      e_hobc[3*i +: 3] = (i % 2 == 1) ? 3'b111 : 3'b000;
      e_lob[5*i +: 5]  = (i % 2 == 1) ? 5'b00001 : 5'b11111;
    end
    chk("mix_wr_en", 64'(wr_en), 64'd1);
    chk("mix_addr", 64'(wr_addr), 64'd2);
    chk("mix_hob", 64'(wr_hob), 64'(e_hob));
    chk("mix_hob_c", 64'(wr_hob_c), 64'(e_hobc));
    chk("mix_lob", 64'(wr_lob), 64'(e_lob));
    chk_counters("mix");
    tick;

    // Stall: buffer fills at four, nothing dropped, drains in order back-to-back
    stall = 1'b1;
    offer_stalled(6, n_acc, wr_seen);
    chk("stall_accepted", 64'(n_acc), 64'd4);
    chk("stall_full_ready", 64'(up_ready), 64'd0);
    chk("stall_no_write", 64'(wr_seen), 64'd0);
    stall = 1'b0;
    nwr = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (wr_en) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (nwr < 4) begin
          chk($sformatf("drain%0d_addr", nwr), 64'(wr_addr), 64'(nwr));
          chk($sformatf("drain%0d_lob", nwr), 64'(wr_lob), 64'({12{5'(nwr + 1)}}));
        end
        nwr++;
      end
    end
    exp_train += 4;
    chk("drain_count", 64'(nwr), 64'd4);
    chk("drain_consecutive", 64'(last_c - first_c), 64'd3);
    chk("drain_ready", 64'(up_ready), 64'd1);
    chk_counters("drain");

    // Async reset while three writes are still queued
    stall = 1'b1;
    offer_stalled(4, n_acc, wr_seen);
    chk("rst2_accepted", 64'(n_acc), 64'd4);
    stall = 1'b0;
    tick;
    chk("rst2_pre_wr_en", 64'(wr_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    exp_train = 0; exp_skip = 0;
    chk("rst2_wr_en", 64'(wr_en), 64'd0);
    chk("rst2_ready", 64'(up_ready), 64'd0);
    chk_counters("rst2");
    tick;
    reset = 1'b0;
    init_sweep("reinit");
    nwr = 0;
    repeat (6) begin
      tick;
      if (wr_en) nwr++;
    end
    chk("reinit_no_stale", 64'(nwr), 64'd0);
    chk_counters("reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
